// File: rtl/cfg_pkg.sv
// Shared constants, state encoding and CRC step for the config chain loader.
package cfg_pkg;

  // Default field widths of one per-layer config record.
  localparam int unsigned NLAYER_DFLT     = 5;
  localparam int unsigned HW_WIDTH_DFLT   = 5;
  localparam int unsigned T_WIDTH_DFLT    = 5;
  localparam int unsigned D1_WIDTH_DFLT   = 5;
  localparam int unsigned D2_WIDTH_DFLT   = 9;
  localparam int unsigned NCFG_WIDTH_DFLT = 96;
  localparam int unsigned TPD_WIDTH_DFLT  = 4;
  localparam int unsigned NFLAG_BITS      = 4;

  // Record width: all fields plus PD_EN_MEM, PD_EN_CIM, BP, SWP flags.
  function automatic int unsigned rec_width(input int unsigned hw, input int unsigned t,
                                            input int unsigned d1, input int unsigned d2,
                                            input int unsigned ncfg, input int unsigned tpd);
    return hw + t + d1 + d2 + ncfg + tpd + NFLAG_BITS;
  endfunction

  localparam int unsigned REC_WIDTH_DFLT = rec_width(HW_WIDTH_DFLT, T_WIDTH_DFLT, D1_WIDTH_DFLT,
                                                     D2_WIDTH_DFLT, NCFG_WIDTH_DFLT,
                                                     TPD_WIDTH_DFLT);

  // Field LSB offsets within a default-width record.
  localparam int unsigned HW_LSB        = 0;
  localparam int unsigned T_LSB         = HW_LSB + HW_WIDTH_DFLT;
  localparam int unsigned D1_LSB        = T_LSB + T_WIDTH_DFLT;
  localparam int unsigned D2_LSB        = D1_LSB + D1_WIDTH_DFLT;
  localparam int unsigned NCFG_LSB      = D2_LSB + D2_WIDTH_DFLT;
  localparam int unsigned TPD_LSB       = NCFG_LSB + NCFG_WIDTH_DFLT;
  localparam int unsigned PD_EN_MEM_LSB = TPD_LSB + TPD_WIDTH_DFLT;
  localparam int unsigned PD_EN_CIM_LSB = PD_EN_MEM_LSB + 1;
  localparam int unsigned BP_LSB        = PD_EN_CIM_LSB + 1;
  localparam int unsigned SWP_LSB       = BP_LSB + 1;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  typedef enum logic [2:0] {
    StIdle,
    StWaitRec,
    StShift,
    StGap,
    StCheck
  } state_e;

  // One serial CRC-16 step, MSB-first feedback.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
    logic fb;
    fb = crc[15] ^ b;
    return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/cfg_chain_loader_crc16_serial.sv
// Bit-serial CRC-16 accumulator with synchronous clear.
module crc16_serial
  import cfg_pkg::*;
(
  input  logic        clk,
  input  logic        clear,
  input  logic        en,
  input  logic        data_bit,
  output logic [15:0] crc
);

  // Clear wins over an update in the same cycle.
  always_ff @(posedge clk) begin
    if (clear) begin
      crc <= CRC_INIT;
    end else if (en) begin
      crc <= crc16_step(crc, data_bit);
    end
  end

endmodule

// File: rtl/cfg_chain_loader.sv
// Serialises per-layer config records onto the CFG chain, with optional CRC readback pass.
module cfg_chain_loader
  import cfg_pkg::*;
#(
  parameter int unsigned NLAYER     = NLAYER_DFLT,
  parameter int unsigned HW_WIDTH   = HW_WIDTH_DFLT,
  parameter int unsigned T_WIDTH    = T_WIDTH_DFLT,
  parameter int unsigned D1_WIDTH   = D1_WIDTH_DFLT,
  parameter int unsigned D2_WIDTH   = D2_WIDTH_DFLT,
  parameter int unsigned NCFG_WIDTH = NCFG_WIDTH_DFLT,
  parameter int unsigned TPD_WIDTH  = TPD_WIDTH_DFLT
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   START,
  input  logic                   MODE,
  input  logic                   REC_VALID,
  output logic                   REC_READY,
  input  logic [rec_width(HW_WIDTH, T_WIDTH, D1_WIDTH, D2_WIDTH, NCFG_WIDTH, TPD_WIDTH)-1:0]
                                 REC_DATA,
  output logic                   CFG_WE,
  output logic                   CFG_D,
  input  logic                   CFG_Q,
  output logic                   BUSY,
  output logic                   DONE,
  output logic                   ERR,
  output logic [15:0]            CRC
);

  localparam int unsigned REC_WIDTH = rec_width(HW_WIDTH, T_WIDTH, D1_WIDTH, D2_WIDTH,
                                                NCFG_WIDTH, TPD_WIDTH);
  localparam int unsigned BCW = $clog2(REC_WIDTH + 1);
  localparam int unsigned RCW = $clog2(NLAYER + 1);
  localparam logic [BCW-1:0] REC_BITS = BCW'(REC_WIDTH);
  localparam logic [RCW-1:0] NL_CNT   = RCW'(NLAYER);

  state_e               state_q, state_d;
  logic [REC_WIDTH-1:0] sr_q, sr_d;
  logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [RCW-1:0]       rec_cnt_q, rec_cnt_d, rec_cnt_inc;
  logic                 pass_q, pass_d;
  logic                 mode_q, mode_d;
  logic                 we_q, we_d;
  logic                 dout_q, dout_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 crc_clear;
  logic [15:0]          crc_tx, crc_rx;

  assign rec_cnt_inc = rec_cnt_q + 1'b1;

  // Next-state and registered-output values; every output is a flop.
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    rec_cnt_d = rec_cnt_q;
    pass_d    = pass_q;
    mode_d    = mode_q;
    we_d      = 1'b0;
    dout_d    = 1'b0;
    ready_d   = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    crc_clear = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (START) begin
          err_d     = 1'b0;
          crc_clear = 1'b1;
          pass_d    = 1'b0;
          rec_cnt_d = '0;
          busy_d    = 1'b1;
          mode_d    = MODE;
          ready_d   = 1'b1;
          state_d   = StWaitRec;
        end
      end
      StWaitRec: begin
        if (REC_VALID && ready_q) begin
          // Bit 0 goes out in the very next cycle; the rest sits in sr.
          sr_d      = REC_DATA >> 1;
          we_d      = 1'b1;
          dout_d    = REC_DATA[0];
          bit_cnt_d = BCW'(1);
          state_d   = StShift;
        end else begin
          ready_d = 1'b1;
        end
      end
      StShift: begin
        if (bit_cnt_q == REC_BITS) begin
          state_d = StGap;
        end else begin
          we_d      = 1'b1;
          dout_d    = sr_q[0];
          sr_d      = sr_q >> 1;
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      StGap: begin
        rec_cnt_d = rec_cnt_inc;
        if (rec_cnt_inc != NL_CNT) begin
          ready_d = 1'b1;
          state_d = StWaitRec;
        end else if (!pass_q && mode_q) begin
          pass_d    = 1'b1;
          rec_cnt_d = '0;
          ready_d   = 1'b1;
          state_d   = StWaitRec;
        end else begin
          // Final CRCs are settled here, so DONE/ERR land during the CHECK cycle.
          done_d  = 1'b1;
          busy_d  = 1'b0;
          if (mode_q && (crc_rx != crc_tx)) begin
            err_d = 1'b1;
          end
          state_d = StCheck;
        end
      end
      StCheck: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= StIdle;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      rec_cnt_q <= '0;
      pass_q    <= 1'b0;
      mode_q    <= 1'b0;
      we_q      <= 1'b0;
      dout_q    <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      rec_cnt_q <= rec_cnt_d;
      pass_q    <= pass_d;
      mode_q    <= mode_d;
      we_q      <= we_d;
      dout_q    <= dout_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  logic crc_clr_all, tx_en, rx_en;
  assign crc_clr_all = RST | crc_clear;
  assign tx_en       = we_q & ~pass_q;
  assign rx_en       = we_q & pass_q;

  // Pass 0: CRC of bits driven onto CFG_D.
  crc16_serial u_crc_tx (
    .clk      (CLK),
    .clear    (crc_clr_all),
    .en       (tx_en),
    .data_bit (dout_q),
    .crc      (crc_tx)
  );

  // Pass 1: CRC of bits falling out of the chain end.
  crc16_serial u_crc_rx (
    .clk      (CLK),
    .clear    (crc_clr_all),
    .en       (rx_en),
    .data_bit (CFG_Q),
    .crc      (crc_rx)
  );

  assign CFG_WE    = we_q;
  assign CFG_D     = dout_q;
  assign REC_READY = ready_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign ERR       = err_q;
  assign CRC       = crc_tx;

endmodule
